// File: rtl/apb_slave_mem_ws_if.sv
// APB4 signal bundle between a requester and the apb_slave_mem_ws completer.
interface apb_slave_mem_ws_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   paddr;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W/8-1:0] pstrb;
    logic [DATA_W-1:0]   prdata;
    logic                pready;
    logic                pslverr;

    // Handshake: a transfer starts with one cycle of psel=1/penable=0 and continues with
    // psel=1/penable=1 held until the edge where pready=1; pslverr/prdata are valid only then.
    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_mem_ws.sv
// APB4 completer backed by a byte-strobed register file, with programmable wait states
// and pslverr on out-of-range or misaligned addresses.
module apb_slave_mem_ws #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              pclk,
    input  logic              preset,
    apb_slave_mem_ws_if.slave bus,
    output logic [1:0]        dbg_state
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [3:0]        WS_M1    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    // The setup phase is decoded while still in IDLE so that the registered pready
    // lands in access cycle WAIT_STATES+1; ACCESS then covers the pready-low cycles.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       start;
    logic       finish;

    logic [ADDR_W-1:0] lat_addr;
    logic              lat_write;
    logic [DATA_W-1:0] lat_wdata;
    logic [STRB_W-1:0] lat_strb;

    logic [ADDR_W-1:0] req_addr;
    logic              req_write;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_strb;
    logic [ADDR_W-1:0] idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              err;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] prdata_q;
    logic              pready_q;
    logic              pslverr_q;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        start      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.psel && !bus.penable) start = 1'b1;
            end
            ACCESS: begin
                if (!(bus.psel && bus.penable)) state_next = IDLE;
                else if (cnt == 4'd0)           state_next = DONE;
                else                            cnt_next   = cnt - 4'd1;
            end
            DONE: begin
                state_next = IDLE;
                if (bus.psel && !bus.penable) start = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        if (start) begin
            if (WAIT_STATES == 0) begin
                state_next = DONE;
            end else begin
                state_next = ACCESS;
                cnt_next   = WS_M1;
            end
        end
    end

    // A transfer finishing straight out of the setup phase has not latched yet, so it uses the bus.
    always_comb begin
        req_addr  = (state == ACCESS) ? lat_addr  : bus.paddr;
        req_write = (state == ACCESS) ? lat_write : bus.pwrite;
        req_wdata = (state == ACCESS) ? lat_wdata : bus.pwdata;
        req_strb  = (state == ACCESS) ? lat_strb  : bus.pstrb;
        idx       = req_addr >> OFF_W;
        mem_idx   = idx[IDX_W-1:0];
        err       = ((req_addr & OFF_MASK) != '0) || (idx >= DEPTH_A);
        finish    = (state_next == DONE);
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_wdata <= '0;
            lat_strb  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (start) begin
                lat_addr  <= bus.paddr;
                lat_write <= bus.pwrite;
                lat_wdata <= bus.pwdata;
                lat_strb  <= bus.pstrb;
            end
            pready_q  <= finish;
            pslverr_q <= finish && err;
            prdata_q  <= (finish && !err && !req_write) ? mem[mem_idx] : '0;
            if (finish && !err && req_write) begin
                for (int k = 0; k < STRB_W; k++) begin
                    if (req_strb[k]) mem[mem_idx][8*k +: 8] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;
    assign bus.prdata  = prdata_q;
    assign dbg_state   = state;

endmodule

// File: doc/apb_slave_mem_ws.md
Name: apb_slave_mem_ws

Overview:
Parametrised APB4 completer with an internal register-file memory. It generalises the team's fixed APB slave in several ways: configurable address/data width, configurable depth, programmable wait states, byte strobes, and error response on out-of-range or misaligned access. It sits behind the APB bridge as a generic scratch/config memory and is the DUT for the next APB bench generation.

Parameters:
ADDR_W, 8, byte-address width of paddr
DATA_W, 32, data width; legal values 8/16/32/64
DEPTH, 32, number of DATA_W words; must satisfy DEPTH*(DATA_W/8) <= 2**ADDR_W
WAIT_STATES, 0, pready-low access cycles inserted per transfer; legal range 0..15

Ports:
pclk  in  1  clock; all state updates on rising edge
preset  in  1  reset; asynchronous, active-high
paddr  in  ADDR_W  byte address
psel  in  1  slave select
penable  in  1  access-phase indicator
pwrite  in  1  1=write, 0=read
pwdata  in  DATA_W  write data
pstrb  in  DATA_W/8  write byte strobes; ignored on reads
prdata  out  DATA_W  read data
pready  out  1  transfer-complete
pslverr  out  1  error response; valid only when pready=1

Behaviour:
- Reset (preset=1, asynchronous): outputs prdata=0, pready=0, pslverr=0; state=IDLE; wait counter=0; all memory words=0.
- Reset asserted mid-transfer aborts the transfer immediately. No write is committed. The slave restarts in IDLE after reset is released.
- FSM states:
  - IDLE. On psel=1, penable=0: latch paddr/pwrite/pwdata/pstrb, load counter=WAIT_STATES, go to SETUP.
  - SETUP (one cycle). Go to ACCESS. If psel=0, go to IDLE instead.
  - ACCESS. While psel=1 and penable=1: if counter!=0, decrement it and keep pready=0. If counter==0, go to DONE.
  - DONE. Drive pready=1 for exactly one cycle, then go to IDLE. If psel=1 and penable=0 in that same cycle, latch the new request and go directly to SETUP.
- Access phase length is WAIT_STATES+1 cycles. Example: WAIT_STATES=0 gives pready=1 in the first cycle with penable=1.
- pready, pslverr and prdata are registered outputs.
- Address decode:
  - word index = paddr >> log2(DATA_W/8).
  - Error when index >= DEPTH, or when paddr low log2(DATA_W/8) bits are nonzero (misaligned).
- Error response: pslverr=1 together with pready=1. Memory is unchanged and prdata=0.
- Write (no error): committed on the pclk edge that asserts pready. Byte k is written iff pstrb[k]=1. pstrb all-zero is a legal no-op with pslverr=0.
- Read (no error): prdata = mem[index], sampled at the pready edge, so a write completing in the previous transfer is visible. prdata is driven only while pready=1 and is 0 otherwise.
- Protocol violation: if psel or penable drops during ACCESS before pready, abort with no write and no pready, and return to IDLE. penable=1 seen while in IDLE is ignored.
- pready and pslverr are never asserted outside DONE. Write data, address and strobes are used from the SETUP latch, so mid-access changes on the bus have no effect.

Test Plan:
- Reset check: assert preset mid-ACCESS of a write to addr 0x04 (data 0xDEADBEEF). Required: outputs go to 0 asynchronously. After release, a read of 0x04 returns 0x00000000 with pslverr=0.
- Wait states (WAIT_STATES=2): write 0x04 with 0x12345678 and pstrb=0xF, then read 0x04. Required: pready low for 2 access cycles and high on the 3rd; read returns 0x12345678. Repeat with WAIT_STATES=0: pready=1 in the first access cycle.
- Byte strobes: write 0xFFFFFFFF to 0x08, then write 0x000000AA with pstrb=0x1, then read 0x08. Required: 0xFFFFFFAA. A further write with pstrb=0x0 leaves the value unchanged, pslverr=0.
- Errors (DEPTH=32, DATA_W=32): write 0x80 (index 32) and read 0x81 (misaligned). Required: pready=1 with pslverr=1, prdata=0. A following read of 0x7C returns its prior value, showing memory is untouched.
- Back-to-back: 20 random aligned in-range writes, each followed immediately by a read to the same address with no IDLE gap. Required: every read matches the scoreboard and pslverr=0 throughout.
- Abort: drop psel during ACCESS of a write to 0x10 (WAIT_STATES=3). Required: no pready pulse; a later read of 0x10 returns the old value.
